// File: rtl/whac_pkg.sv
// Shared types and default constants for the whac-a-mole scoring path.
// Used by combo_tracker and score_counter so both agree on combo range.
package whac_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAK = 1'b1
    } combo_state_t;

    localparam int unsigned MAX_COMBO_COUNT_DEF = 99;
    localparam int unsigned TIMEOUT_CYCLES_DEF  = 50_000_000;

endpackage

// File: rtl/combo_timeout_timer.sv
// Idle-time counter for an active combo streak.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : restart the count from 0 (takes priority over run)
//   run      : count one cycle while high
//   expire   : combinational, high when the count has reached TIMEOUT_CYCLES-1 and run is high
module combo_timeout_timer
    import whac_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int unsigned      TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]    LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    // Count stalls at LAST so it can never run past the timeout value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (run && (count != LAST)) begin
            count <= count + TW'(1);
        end
    end

    assign expire = run && (count == LAST);

endmodule

// File: rtl/combo_tracker.sv
// Hit-streak (combo) tracker feeding score_counter.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   game_active : level, high while a round is running
//   hit, miss   : one-cycle judgement pulses from the hit judge
//   combo_count : registered current streak, saturating at MAX_COMBO_COUNT
//   combo_break : registered one-cycle pulse when a non-zero streak returns to 0
//   best_combo  : registered highest combo_count since reset
module combo_tracker
    import whac_pkg::*;
#(
    parameter int unsigned MAX_COMBO_COUNT = MAX_COMBO_COUNT_DEF,
    parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               game_active,
    input  logic                               hit,
    input  logic                               miss,
    output logic [$clog2(MAX_COMBO_COUNT)-1:0] combo_count,
    output logic                               combo_break,
    output logic [$clog2(MAX_COMBO_COUNT)-1:0] best_combo
);

    localparam int unsigned   CW        = $clog2(MAX_COMBO_COUNT);
    localparam logic [CW-1:0] COMBO_MAX = CW'(MAX_COMBO_COUNT);

    combo_state_t  state;
    combo_state_t  state_next;
    logic [CW-1:0] combo_next;
    logic          break_next;
    logic          timer_clear;
    logic          timer_run;
    logic          expire;

    // Timer runs only during a streak; any event (or a timeout) restarts it.
    assign timer_run   = (state == STREAK);
    assign timer_clear = !game_active || miss || hit || expire;

    combo_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .run   (timer_run),
        .expire(expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; priority is game_active, miss, hit, then timeout.
    always_comb begin
        state_next = state;
        if (!game_active) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!miss && hit) begin
                        state_next = STREAK;
                    end
                end
                STREAK: begin
                    if (miss) begin
                        state_next = IDLE;
                    end else if (!hit && expire) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Next combo value and break pulse, registered below.
    always_comb begin
        combo_next = combo_count;
        break_next = 1'b0;
        if (!game_active) begin
            combo_next = '0;
            break_next = (combo_count != '0);
        end else begin
            unique case (state)
                IDLE: begin
                    if (!miss && hit) begin
                        combo_next = CW'(1);
                    end
                end
                STREAK: begin
                    if (miss) begin
                        combo_next = '0;
                        break_next = 1'b1;
                    end else if (hit) begin
                        combo_next = (combo_count == COMBO_MAX) ? COMBO_MAX
                                                                : combo_count + CW'(1);
                    end else if (expire) begin
                        combo_next = '0;
                        break_next = 1'b1;
                    end
                end
                default: begin
                    combo_next = '0;
                end
            endcase
        end
    end

    // Output registers; best_combo tracks the new combo value on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            combo_count <= '0;
            combo_break <= 1'b0;
            best_combo  <= '0;
        end else begin
            combo_count <= combo_next;
            combo_break <= break_next;
            if (combo_next > best_combo) begin
                best_combo <= combo_next;
            end
        end
    end

endmodule

// File: tb/tb_combo_tracker.sv
module tb_combo_tracker;

    localparam int unsigned T = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_active;
    logic       hit;
    logic       miss;
    logic [6:0] ca;
    logic [6:0] ba;
    logic       bka;
    logic [2:0] cs;
    logic [2:0] bs;
    logic       bks;

    always #5 clk = ~clk;

    combo_tracker #(.MAX_COMBO_COUNT(99), .TIMEOUT_CYCLES(T)) dut_a (
        .clk(clk), .rst(rst), .game_active(game_active), .hit(hit), .miss(miss),
        .combo_count(ca), .combo_break(bka), .best_combo(ba)
    );

    combo_tracker #(.MAX_COMBO_COUNT(5), .TIMEOUT_CYCLES(T)) dut_s (
        .clk(clk), .rst(rst), .game_active(game_active), .hit(hit), .miss(miss),
        .combo_count(cs), .combo_break(bks), .best_combo(bs)
    );

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference: streak length, edge index of the last counted hit, best, break flag.
    int m_combo[2];
    int m_best[2];
    int m_last[2];
    bit m_brk[2];
    int maxv[2] = '{99, 5};
    int score_s = 0;
    int prev_s  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step(input bit r, input bit a, input bit h, input bit m);
        for (int i = 0; i < 2; i++) begin
            m_brk[i] = 1'b0;
            if (r) begin
                m_combo[i] = 0;
                m_best[i]  = 0;
            end else if (!a || m) begin
                m_brk[i]   = (m_combo[i] != 0);
                m_combo[i] = 0;
            end else if (h) begin
                m_combo[i] = (m_combo[i] + 1 > maxv[i]) ? maxv[i] : m_combo[i] + 1;
                m_last[i]  = cyc;
            end else if (m_combo[i] != 0 && (cyc - m_last[i]) >= int'(T)) begin
                m_combo[i] = 0;
                m_brk[i]   = 1'b1;
            end
            if (m_combo[i] > m_best[i]) m_best[i] = m_combo[i];
        end
    endtask

    task automatic tick(input bit r, input bit a, input bit h, input bit m);
        rst = r; game_active = a; hit = h; miss = m;
        @(posedge clk);
        cyc++;
        model_step(r, a, h, m);
        #1;
        check("combo_a", 32'(ca),  32'(m_combo[0]));
        check("break_a", 32'(bka), 32'(m_brk[0]));
        check("best_a",  32'(ba),  32'(m_best[0]));
        check("combo_s", 32'(cs),  32'(m_combo[1]));
        check("break_s", 32'(bks), 32'(m_brk[1]));
        check("best_s",  32'(bs),  32'(m_best[1]));
        if (r) begin
            score_s = 0;
            prev_s  = 0;
        end else if (int'(cs) != prev_s) begin
            score_s += int'(cs);
            prev_s   = int'(cs);
        end
    endtask

    initial begin
        // Reset and spaced hits
        tick(1, 1, 0, 0);
        check("reset_combo", 32'(ca), 0);
        check("reset_best", 32'(ba), 0);
        check("reset_break", 32'(bka), 0);
        for (int k = 0; k < 3; k++) begin
            tick(0, 1, 1, 0);
            check("spaced_hit", 32'(ca), 32'(k + 1));
            for (int j = 0; j < 4; j++) tick(0, 1, 0, 0);
        end
        check("best_after_3", 32'(ba), 3);

        // Miss and simultaneous hit+miss
        tick(0, 1, 1, 0);
        check("combo_4", 32'(ca), 4);
        tick(0, 1, 1, 1);
        check("hitmiss_combo", 32'(ca), 0);
        check("hitmiss_break", 32'(bka), 1);
        tick(0, 1, 0, 0);
        check("break_one_cycle", 32'(bka), 0);
        tick(0, 1, 0, 1);
        check("idle_miss_nobreak", 32'(bka), 0);
        check("best_kept_4", 32'(ba), 4);

        // Timeout: combo reads 1 for exactly T cycles
        tick(0, 1, 1, 0);
        for (int i = 1; i < int'(T); i++) begin
            tick(0, 1, 0, 0);
            check("timeout_hold", 32'(ca), 1);
        end
        tick(0, 1, 0, 0);
        check("timeout_combo", 32'(ca), 0);
        check("timeout_break", 32'(bka), 1);
        // Hit on the timeout cycle continues the streak
        tick(0, 1, 1, 0);
        for (int i = 1; i < int'(T); i++) tick(0, 1, 0, 0);
        tick(0, 1, 1, 0);
        check("timeout_hit_combo", 32'(ca), 2);
        check("timeout_hit_nobreak", 32'(bka), 0);
        for (int i = 0; i < int'(T) + 2; i++) tick(0, 1, 0, 0);

        // Saturation
        tick(1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 1, 0);
            check("sat_seq", 32'(cs), 32'((i + 1 > 5) ? 5 : i + 1));
        end
        check("sat_best", 32'(bs), 5);
        check("sat_score", 32'(score_s), 15);

        // game_active drop at combo 6
        tick(1, 1, 0, 0);
        for (int i = 0; i < 6; i++) tick(0, 1, 1, 0);
        check("pre_drop_combo", 32'(ca), 6);
        tick(0, 0, 1, 0);
        check("drop_combo", 32'(ca), 0);
        check("drop_break", 32'(bka), 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, i[0]);
            check("inactive_combo", 32'(ca), 0);
            check("inactive_nobreak", 32'(bka), 0);
        end
        check("drop_best", 32'(ba), 6);

        // Reset mid-streak
        tick(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) tick(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
        check("pre_rst_combo", 32'(ca), 7);
        tick(1, 1, 0, 0);
        check("rst_combo", 32'(ca), 0);
        check("rst_best", 32'(ba), 0);
        check("rst_break", 32'(bka), 0);
        tick(0, 1, 1, 0);
        check("post_rst_hit", 32'(ca), 1);

        // Randomized traffic against the reference
        for (int i = 0; i < 600; i++) begin
            tick(($urandom % 97) == 0, ($urandom % 20) != 0,
                 ($urandom % 4) == 0, ($urandom % 13) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
